// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle radix-2 sequencer for RV32M MUL/DIV/DIVU/REM/REMU.
//            Optional macro MULDIV_EARLY_OUT_EN resolves trivial ops at issue.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int                 c_cnt_w     = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   c_int_min   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state, w_state_next;
  logic [2:0]         r_funct3;
  logic [WIDTH-1:0]   r_op_a, r_op_b;
  logic [WIDTH-1:0]   r_x;    // multiplier (shifts right) / dividend becoming quotient
  logic [WIDTH-1:0]   r_y;    // multiplicand (shifts left) / divisor magnitude
  logic [WIDTH-1:0]   r_acc;  // product / partial remainder
  logic               r_neg_q, r_neg_r;
  logic [c_cnt_w-1:0] r_cnt;
  logic [TAG_W-1:0]   r_tag_pend, r_tag_out;
  logic [WIDTH-1:0]   r_result;

  logic               w_accept, w_early, w_load_result, w_signed_in;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_fix_res, w_early_res, w_result_next;
  logic [WIDTH:0]     w_rem_sh, w_diff, w_spec_fix;
  logic [TAG_W-1:0]   w_tag_next;

  // Returns {hit, value} for div-by-zero, signed overflow and zero-operand MUL.
  function automatic logic [WIDTH:0] special_case(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = '0;
    if (f == 3'b000) begin
      if (a == '0 || b == '0) s = {1'b1, {WIDTH{1'b0}}};
    end else if (f[2]) begin
      if (b == '0)
        s = {1'b1, (f[1] ? a : {WIDTH{1'b1}})};
      else if (!f[0] && a == c_int_min && b == '1)
        s = {1'b1, (f[1] ? {WIDTH{1'b0}} : c_int_min)};
    end
    return s;
  endfunction

  assign w_signed_in = funct3[2] & ~funct3[0];
  assign w_mag_a     = (w_signed_in && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_mag_b     = (w_signed_in && op_b[WIDTH-1]) ? -op_b : op_b;
  assign w_rem_sh    = {r_acc, r_x[WIDTH-1]};
  assign w_diff      = w_rem_sh - {1'b0, r_y};

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH:0] w_spec_in;
  assign w_spec_in   = special_case(funct3, op_a, op_b);
  assign w_early     = w_spec_in[WIDTH];
  assign w_early_res = w_spec_in[WIDTH-1:0];
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  always_comb begin
    w_spec_fix = special_case(r_funct3, r_op_a, r_op_b);
    w_fix_res  = '0;
    if (!(r_funct3 == 3'b000 || r_funct3[2]))
      w_fix_res = '0;
    else if (w_spec_fix[WIDTH])
      w_fix_res = w_spec_fix[WIDTH-1:0];
    else if (!r_funct3[2])
      w_fix_res = r_acc;
    else if (r_funct3[1])
      w_fix_res = r_neg_r ? -r_acc : r_acc;
    else
      w_fix_res = r_neg_q ? -r_x : r_x;
  end

  always_comb begin
    w_accept     = start && (r_state == S_IDLE) && !abort;
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    stall        = (start && r_state == S_IDLE) || r_state == S_CALC || r_state == S_FIX;
    done         = (r_state == S_DONE) && !abort;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_early ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == c_last_iter) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (abort) w_state_next = S_IDLE;
  end

  assign w_load_result = !abort && ((r_state == S_FIX) || (w_accept && w_early));
  assign w_result_next = (r_state == S_FIX) ? w_fix_res : w_early_res;
  assign w_tag_next    = (r_state == S_FIX) ? r_tag_pend : tag_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3   <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_acc      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_cnt      <= '0;
      r_tag_pend <= '0;
      r_tag_out  <= '0;
      r_result   <= '0;
    end else begin
      if (w_accept) begin
        r_funct3   <= funct3;
        r_op_a     <= op_a;
        r_op_b     <= op_b;
        r_tag_pend <= tag_in;
        r_cnt      <= '0;
        r_acc      <= '0;
        r_neg_q    <= w_signed_in & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        r_neg_r    <= w_signed_in & op_a[WIDTH-1];
        r_x        <= funct3[2] ? w_mag_a : op_b;
        r_y        <= funct3[2] ? w_mag_b : op_a;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
        if (r_funct3[2]) begin
          // Restoring step: keep the shifted remainder when the trial subtract borrows.
          r_x   <= {r_x[WIDTH-2:0], ~w_diff[WIDTH]};
          r_acc <= w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
        end else begin
          if (r_x[0]) r_acc <= r_acc + r_y;
          r_x <= r_x >> 1;
          r_y <= r_y << 1;
        end
      end
      if (w_load_result) begin
        r_result  <= w_result_next;
        r_tag_out <= w_tag_next;
      end
    end
  end

  assign result  = r_result;
  assign tag_out = r_tag_out;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Randomized and directed bench for muldiv_sequencer against an
//            arithmetic reference model (honours MULDIV_EARLY_OUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             start  = 1'b0;
  logic             abort  = 1'b0;
  logic [2:0]       funct3 = '0;
  logic [WIDTH-1:0] op_a   = '0;
  logic [WIDTH-1:0] op_b   = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             busy, stall, done;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] tag_out;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_sequencer #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .tag_in(tag_in), .busy(busy), .stall(stall),
    .done(done), .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'b000:  return 32'(ua * ub);
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'b110:  return (b == 0) ? a : 32'(sa % sb);
      3'b111:  return (b == 0) ? a : 32'(ua % ub);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if ((f == 3'b000 && (a == 0 || b == 0)) || (f[2] && b == 0) ||
        ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      return 0;
`endif
    return WIDTH + 1;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; tag_in = t; start = 1'b1;
    #1 check("stall_at_issue", stall, 1);
    @(posedge clk);
    #1 start = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; tag_in = 5'($urandom);
  endtask

  // k = number of clock edges after the issue edge before done is seen high.
  task automatic wait_done(input int poke_at, output int k);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      start = (k == poke_at);
      if (start) begin
        funct3 = 3'b000; op_a = $urandom; op_b = $urandom; tag_in = ~tag_in;
      end
      if (done) break;
      k++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t, input int poke_at);
    int k;
    issue(f, a, b, t);
    wait_done(poke_at, k);
    check({name, "_lat"}, k, exp_lat(f, a, b));
    check({name, "_res"}, result, ref_model(f, a, b));
    check({name, "_tag"}, tag_out, t);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 0);
    check({name, "_idle"}, busy, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone;
    logic [31:0] held;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_tag", tag_out, 0);
    check("rst_stall", stall, 0);

    run_op("mul_7_m3",   3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, -1);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 5'd2, -1);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, -1);
    run_op("divu_max_2", 3'b101, 32'hFFFF_FFFF, 32'd2, 5'd4, -1);
    run_op("remu_10_3",  3'b111, 32'd10, 32'd3, 5'd5, -1);
    run_op("div_5_0",    3'b100, 32'd5, 32'd0, 5'd6, -1);
    run_op("rem_5_0",    3'b110, 32'd5, 32'd0, 5'd7, -1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, -1);
    run_op("mul_zero",   3'b000, 32'd0, 32'h1234_5678, 5'd10, -1);
    run_op("illegal",    3'b010, 32'd9, 32'd3, 5'd11, -1);

    // A start pulse mid-op must leave the running op untouched and add no done.
    run_op("busy_start", 3'b101, 32'd100, 32'd7, 5'd13, 10);
    ndone = 0;
    repeat (40) @(negedge clk) ndone += int'(done);
    check("busy_start_no_extra_done", ndone, 0);

    // Abort in CALC, then a fresh op on the following cycle.
    held = result;
    issue(3'b000, 32'd3, 32'd5, 5'd20);
    ndone = 0;
    repeat (15) @(negedge clk) ndone += int'(done);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", ndone + int'(done), 0);
    check("abort_result_held", result, held);
    run_op("after_abort", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd21, -1);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom), -1);
    end

    // Asynchronous reset in the middle of an op.
    run_op("pre_rst", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd30, -1);
    issue(3'b100, 32'd1000, 32'd3, 5'd31);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, 0);
    check("midrst_tag", tag_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_mul", 3'b000, 32'h0001_0000, 32'h0001_0000, 5'd17, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
